// File: rtl/ifetch_pc_seq_if.sv
// ---------------------------------------------------------------------------
// ifetch_pc_seq_if
// Instruction-memory fetch bus between the IFETCH sequencer and imem.
//   imem_req    sequencer -> imem  fetch request (held until ack or reset)
//   imem_addr   sequencer -> imem  word fetch address
//   imem_ack    imem -> sequencer  imem_rdata valid this cycle; completes req
//   imem_rdata  imem -> sequencer  instruction word
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface ifetch_pc_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_pc_seq.sv
// ---------------------------------------------------------------------------
// ifetch_pc_seq
// MIPS IFETCH sequencer: owns the PC, issues word fetches over a req/ack
// bus, presents instructions to decode through a one-entry skid buffer and
// applies branch/jump redirects (no delay slot).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall                         decode not accepting instr_out this cycle
//   branch_taken, branch_target   branch redirect strobe and destination
//   jump, jump_target             J/JAL redirect strobe and destination
//   bus (master)                  imem_req/imem_addr out, imem_ack/imem_rdata in
//   instr_out, instr_valid        instruction presented to decode
//   pc_out                        address of instr_out
//   pcplus4_out, pcplus4_hi       pc_out + 4 and its top nibble (jump targets)
//   misalign_err                  sticky: a redirect target was not word aligned
// ---------------------------------------------------------------------------
module ifetch_pc_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   jump,
  input  logic [31:0]            jump_target,
  ifetch_pc_seq_if.master        bus,
  output logic [31:0]            instr_out,
  output logic                   instr_valid,
  output logic [31:0]            pc_out,
  output logic [31:0]            pcplus4_out,
  output logic [3:0]             pcplus4_hi,
  output logic                   misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_pc;
  logic [31:0] skid;
  logic [31:0] skid_pc;

  logic        redir;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;

  // Branch wins over jump when both strobe in the same cycle.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    redir   = branch_taken | jump;
    tgt_raw = jump_target;
    if (branch_taken) tgt_raw = branch_target;
    tgt     = {tgt_raw[31:2], 2'b00};
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc;
  assign pcplus4_out   = pc_out + 32'd4;
  assign pcplus4_hi    = pcplus4_out[31:28];

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; this also makes the trailing redirect override of
  // instr_valid below a clean "last assignment wins".
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_q        <= 1'b0;
      pc           <= RESET_PC;
      pend         <= 1'b0;
      pend_pc      <= RESET_PC;
      skid         <= 32'h0;
      skid_pc      <= RESET_PC;
      instr_out    <= 32'h0;
      instr_valid  <= 1'b0;
      pc_out       <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      if (redir && (tgt_raw[1:0] != 2'b00)) misalign_err <= 1'b1;

      unique case (state)
        S_IDLE: begin
          state <= S_FETCH;
          req_q <= 1'b1;
          if (redir) pc <= tgt;
        end

        S_FETCH: begin
          if (bus.imem_ack) begin
            if (redir || pend) begin
              // Wrong-path word: drop it and restart at the redirect target.
              pc   <= redir ? tgt : pend_pc;
              pend <= 1'b0;
              if (!stall) instr_valid <= 1'b0;
            end else if (!stall) begin
              instr_out   <= bus.imem_rdata;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
            end else begin
              // Decode still holds the previous word: park this one.
              skid    <= bus.imem_rdata;
              skid_pc <= pc;
              pc      <= pc + 32'd4;
              state   <= S_HOLD;
              req_q   <= 1'b0;
            end
          end else begin
            // pc stays put while the request is outstanding; a redirect is
            // remembered and applied once the in-flight word returns.
            if (redir) begin
              pend    <= 1'b1;
              pend_pc <= tgt;
            end
            if (!stall) instr_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (redir) begin
            pc    <= tgt;
            pend  <= 1'b0;
            state <= S_FETCH;
            req_q <= 1'b1;
          end else if (!stall) begin
            instr_out   <= skid;
            pc_out      <= skid_pc;
            instr_valid <= 1'b1;
            state       <= S_FETCH;
            req_q       <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase

      // No delay slot: a redirect kills whatever decode would see next.
      if (redir) instr_valid <= 1'b0;
    end
  end

endmodule
